// File: rtl/pmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// pmem_arbiter_if
// Bundles the signals of the physical-memory arbiter:
//   - I-cache side: line-fill request, address, returned data and resp pulse
//   - D-cache side: fill/writeback request, address, wdata, returned data, resp
//   - physical port: read/write strobes, address, wdata, rdata, resp
//   - busy status
// modport master : the arbiter itself (samples requests, drives the pmem port)
// modport slave  : the surrounding system (caches and physical memory)
// -----------------------------------------------------------------------------
interface pmem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  // I-cache side
  logic                  icache_pmem_read;
  logic [ADDR_WIDTH-1:0] icache_pmem_address;
  logic [LINE_WIDTH-1:0] icache_pmem_rdata;
  logic                  icache_pmem_resp;
  // D-cache side
  logic                  dcache_pmem_read;
  logic                  dcache_pmem_write;
  logic [ADDR_WIDTH-1:0] dcache_pmem_address;
  logic [LINE_WIDTH-1:0] dcache_pmem_wdata;
  logic [LINE_WIDTH-1:0] dcache_pmem_rdata;
  logic                  dcache_pmem_resp;
  // physical memory port
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;
  // status
  logic                  busy;

  modport master (
    input  icache_pmem_read, icache_pmem_address,
    output icache_pmem_rdata, icache_pmem_resp,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output dcache_pmem_rdata, dcache_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output busy
  );

  modport slave (
    output icache_pmem_read, icache_pmem_address,
    input  icache_pmem_rdata, icache_pmem_resp,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  dcache_pmem_rdata, dcache_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  busy
  );
endinterface

// File: rtl/pmem_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_arbiter
// Shares the single physical-memory port between the I-cache and the D-cache.
// One requester is granted at a time; its address, op and (for writebacks)
// write data are latched on the grant edge and drive the physical port until
// pmem_resp. Ties alternate with the previous grant so neither side starves.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : pmem_arbiter_if.master (cache requests/responses, pmem port, busy)
// -----------------------------------------------------------------------------
module pmem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic          clk,
  input  logic          reset_n,
  pmem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e                state_q;
  logic                  last_grant_dcache_q;  // 0: I-cache was granted last
  logic                  pmem_read_q;
  logic                  pmem_write_q;
  logic [ADDR_WIDTH-1:0] pmem_address_q;
  logic [LINE_WIDTH-1:0] pmem_wdata_q;

  logic i_req;
  logic d_req;
  logic grant_dcache;

  assign i_req = bus.icache_pmem_read;
  assign d_req = bus.dcache_pmem_read | bus.dcache_pmem_write;

  // D wins when it is alone, or on a tie when I was granted last.
  assign grant_dcache = d_req & (~i_req | ~last_grant_dcache_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q             <= IDLE;
      last_grant_dcache_q <= 1'b0;
      pmem_read_q         <= 1'b0;
      pmem_write_q        <= 1'b0;
      pmem_address_q      <= '0;
      pmem_wdata_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            last_grant_dcache_q <= grant_dcache;
            if (grant_dcache) begin
              state_q        <= SERVE_D;
              pmem_address_q <= bus.dcache_pmem_address;
              // read+write together is illegal; the write takes precedence
              pmem_write_q   <= bus.dcache_pmem_write;
              pmem_read_q    <= ~bus.dcache_pmem_write;
              if (bus.dcache_pmem_write) begin
                pmem_wdata_q <= bus.dcache_pmem_wdata;
              end
            end else begin
              state_q        <= SERVE_I;
              pmem_address_q <= bus.icache_pmem_address;
              pmem_read_q    <= 1'b1;
              pmem_write_q   <= 1'b0;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          // Requester inputs are ignored here: only pmem_resp ends a serve.
          if (bus.pmem_resp) begin
            state_q      <= RELEASE;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
          end
        end
        RELEASE: begin
          // Dead cycle so the served cache can drop its request.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_address_q;
  assign bus.pmem_wdata   = pmem_wdata_q;

  // Response steered combinationally to the granted side only.
  assign bus.icache_pmem_resp  = bus.pmem_resp & (state_q == SERVE_I);
  assign bus.dcache_pmem_resp  = bus.pmem_resp & (state_q == SERVE_D);
  assign bus.icache_pmem_rdata = bus.pmem_rdata;
  assign bus.dcache_pmem_rdata = bus.pmem_rdata;

  assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_pmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pmem_arbiter
// Directed scenarios followed by randomized traffic, every cycle compared with
// a transaction-level reference model of the arbiter.
// -----------------------------------------------------------------------------
module tb_pmem_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  logic clk;
  logic reset_n;

  pmem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Illegal D request combination must never be driven.
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(bus.dcache_pmem_read && bus.dcache_pmem_write))
        else $error("illegal D read+write request");
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_vec;
  int n_bad;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one outstanding transaction record plus a mandatory
  // dead cycle after each completion.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit dside;
    bit rd;
    bit wr;
  } txn_t;

  bit          m_active;
  bit          m_dead;
  bit          m_last_was_d;
  txn_t        m_cur;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;

  task automatic model_reset();
    m_active     = 1'b0;
    m_dead       = 1'b0;
    m_last_was_d = 1'b0;
    m_cur        = '{dside: 1'b0, rd: 1'b0, wr: 1'b0};
    m_addr       = '0;
    m_wdata      = '0;
  endtask

  task automatic model_edge();
    bit ireq;
    bit dreq;
    bit take_d;
    ireq = bus.icache_pmem_read;
    dreq = bus.dcache_pmem_read | bus.dcache_pmem_write;
    if (!reset_n) begin
      model_reset();
    end else if (m_active) begin
      if (bus.pmem_resp) begin
        m_active = 1'b0;
        m_dead   = 1'b1;
      end
    end else if (m_dead) begin
      m_dead = 1'b0;
    end else if (ireq || dreq) begin
      take_d       = dreq && (!ireq || !m_last_was_d);
      m_cur.dside  = take_d;
      m_cur.wr     = take_d && bus.dcache_pmem_write;
      m_cur.rd     = !m_cur.wr;
      m_addr       = take_d ? bus.dcache_pmem_address : bus.icache_pmem_address;
      if (m_cur.wr) m_wdata = bus.dcache_pmem_wdata;
      m_last_was_d = take_d;
      m_active     = 1'b1;
    end
  endtask

  // Compare every output at the falling edge, then advance one clock.
  task automatic cyc();
    @(negedge clk);
    chk("pmem_read",  bus.pmem_read,  m_active && m_cur.rd);
    chk("pmem_write", bus.pmem_write, m_active && m_cur.wr);
    chk("pmem_address", bus.pmem_address, m_addr);
    chk("pmem_wdata", bus.pmem_wdata, m_wdata);
    chk("icache_resp", bus.icache_pmem_resp, m_active && !m_cur.dside && bus.pmem_resp);
    chk("dcache_resp", bus.dcache_pmem_resp, m_active && m_cur.dside && bus.pmem_resp);
    chk("busy", bus.busy, m_active || m_dead);
    chk("icache_rdata", bus.icache_pmem_rdata, bus.pmem_rdata);
    chk("dcache_rdata", bus.dcache_pmem_rdata, bus.pmem_rdata);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    bus.icache_pmem_read    = 1'b0;
    bus.icache_pmem_address = '0;
    bus.dcache_pmem_read    = 1'b0;
    bus.dcache_pmem_write   = 1'b0;
    bus.dcache_pmem_address = '0;
    bus.dcache_pmem_wdata   = '0;
    bus.pmem_rdata          = '0;
    bus.pmem_resp           = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pmem_read",  bus.pmem_read,  1'b0);
    chk("rst_pmem_write", bus.pmem_write, 1'b0);
    chk("rst_pmem_address", bus.pmem_address, '0);
    chk("rst_pmem_wdata", bus.pmem_wdata, '0);
    chk("rst_icache_resp", bus.icache_pmem_resp, 1'b0);
    chk("rst_dcache_resp", bus.dcache_pmem_resp, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    reset_n = 1'b1;
    cyc();
  endtask

  // Drive one pmem_resp cycle and confirm it reaches only the expected side.
  task automatic respond(input bit dside, input string tag);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    chk({tag, "_icache_resp"}, bus.icache_pmem_resp, !dside);
    chk({tag, "_dcache_resp"}, bus.dcache_pmem_resp, dside);
    cyc();
    bus.pmem_resp = 1'b0;
  endtask

  // Advance until a strobe appears; expiry is reported as a failed check.
  task automatic wait_strobe(input string tag);
    bit seen;
    seen = bus.pmem_read || bus.pmem_write;
    for (int k = 0; k < 8 && !seen; k++) begin
      cyc();
      seen = bus.pmem_read || bus.pmem_write;
    end
    chk({tag, "_strobe_seen"}, seen, 1'b1);
  endtask

  localparam logic [LW-1:0] A5_LINE   = {16{8'hA5}};
  localparam logic [LW-1:0] DEAD_LINE = 128'hDEAD_C0DE_0000_1111_2222_3333_4444_BEEF;

  initial begin
    int  op;
    bit  exp_d;
    n_vec   = 0;
    n_bad   = 0;
    reset_n = 1'b1;
    clear_inputs();
    model_reset();

    // ---- I alone ----
    do_reset();
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 16'h1230;
    cyc();                                  // cycle 1
    chk("ialone_read", bus.pmem_read, 1'b1);
    chk("ialone_addr", bus.pmem_address, 16'h1230);
    cyc(); cyc(); cyc();                    // cycle 4
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = A5_LINE;
    #1;
    chk("ialone_iresp", bus.icache_pmem_resp, 1'b1);
    chk("ialone_irdata", bus.icache_pmem_rdata, A5_LINE);
    chk("ialone_dresp", bus.dcache_pmem_resp, 1'b0);
    cyc();                                  // cycle 5
    bus.pmem_resp        = 1'b0;
    bus.icache_pmem_read = 1'b0;
    chk("ialone_read_off", bus.pmem_read, 1'b0);
    chk("ialone_busy5", bus.busy, 1'b1);
    cyc();                                  // cycle 6
    chk("ialone_busy6", bus.busy, 1'b0);

    // ---- tie after reset: D first ----
    do_reset();
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 16'h0100;
    bus.dcache_pmem_write   = 1'b1;
    bus.dcache_pmem_address = 16'h4000;
    bus.dcache_pmem_wdata   = DEAD_LINE;
    cyc();
    chk("tie_d_write", bus.pmem_write, 1'b1);
    chk("tie_d_read",  bus.pmem_read, 1'b0);
    chk("tie_d_addr",  bus.pmem_address, 16'h4000);
    chk("tie_d_wdata", bus.pmem_wdata, DEAD_LINE);
    cyc();
    respond(1'b1, "tie_d");
    bus.dcache_pmem_write = 1'b0;
    chk("tie_release_strobe", bus.pmem_read | bus.pmem_write, 1'b0);
    cyc();
    chk("tie_idle_strobe", bus.pmem_read | bus.pmem_write, 1'b0);
    cyc();
    chk("tie_i_read", bus.pmem_read, 1'b1);
    chk("tie_i_addr", bus.pmem_address, 16'h0100);
    cyc();
    respond(1'b0, "tie_i");
    bus.icache_pmem_read = 1'b0;
    cyc(); cyc();

    // ---- alternation with both held ----
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 16'h1000;
    bus.dcache_pmem_read    = 1'b1;
    bus.dcache_pmem_address = 16'hD000;
    for (int g = 0; g < 4; g++) begin
      exp_d = (g % 2 == 0);
      wait_strobe("alt");
      chk("alt_order_addr", bus.pmem_address, exp_d ? 16'hD000 : 16'h1000);
      cyc(); cyc(); cyc();
      respond(exp_d, "alt");
    end
    bus.icache_pmem_read = 1'b0;
    bus.dcache_pmem_read = 1'b0;
    cyc(); cyc();

    // ---- request drop mid-serve ----
    bus.dcache_pmem_read    = 1'b1;
    bus.dcache_pmem_address = 16'h2000;
    cyc();
    chk("drop_read", bus.pmem_read, 1'b1);
    chk("drop_addr", bus.pmem_address, 16'h2000);
    bus.dcache_pmem_read    = 1'b0;
    bus.dcache_pmem_address = 16'h3000;
    cyc();
    chk("drop_read_held", bus.pmem_read, 1'b1);
    chk("drop_addr_held", bus.pmem_address, 16'h2000);
    cyc();
    respond(1'b1, "drop");
    cyc();

    // ---- spurious resp in IDLE ----
    bus.pmem_resp = 1'b1;
    #1;
    chk("spur_iresp", bus.icache_pmem_resp, 1'b0);
    chk("spur_dresp", bus.dcache_pmem_resp, 1'b0);
    cyc();
    bus.pmem_resp = 1'b0;
    chk("spur_busy", bus.busy, 1'b0);
    chk("spur_read", bus.pmem_read, 1'b0);

    // ---- asynchronous reset mid-serve ----
    bus.dcache_pmem_write   = 1'b1;
    bus.dcache_pmem_address = 16'h5000;
    bus.dcache_pmem_wdata   = {4{32'h1357_9BDF}};
    cyc();
    chk("rstmid_write_before", bus.pmem_write, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstmid_read",  bus.pmem_read, 1'b0);
    chk("rstmid_write", bus.pmem_write, 1'b0);
    chk("rstmid_busy",  bus.busy, 1'b0);
    model_reset();
    bus.dcache_pmem_write = 1'b0;
    @(posedge clk);
    #1;
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 16'h0700;
    bus.dcache_pmem_read    = 1'b1;
    bus.dcache_pmem_address = 16'h6000;
    reset_n = 1'b1;
    cyc();
    chk("rstmid_tie_d_read", bus.pmem_read, 1'b1);
    chk("rstmid_tie_d_addr", bus.pmem_address, 16'h6000);
    cyc();
    respond(1'b1, "rstmid");
    bus.dcache_pmem_read = 1'b0;

    // ---- randomized traffic ----
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) begin
        bus.icache_pmem_read    = 1'($urandom_range(1));
        bus.icache_pmem_address = AW'($urandom);
      end
      if ($urandom_range(3) == 0) begin
        op = $urandom_range(2);
        bus.dcache_pmem_read    = (op == 1);
        bus.dcache_pmem_write   = (op == 2);
        bus.dcache_pmem_address = AW'($urandom);
        bus.dcache_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
      bus.pmem_resp  = ($urandom_range(3) == 0);
      bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
